// File: rtl/ram_arb_pkg.sv
// Shared types and default sizes for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot combinational grant, favouring the port not granted last.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  // Reset value 1 makes port 0 win the first contention.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      last_q <= 1'b1;
    end else if (gnt_o != 2'b00) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Shares one single-port synchronous RAM between two requesters with round-robin arbitration
// and an optional post-reset zero fill. Define RAM_ARB_STATS_EN to add grant/conflict counters.
module ram_arbiter_2p
  import ram_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic            p0_req,
  input  logic [DW/8-1:0] p0_we,
  input  logic [AW-1:0]   p0_addr,
  input  logic [DW-1:0]   p0_wdata,
  input  logic            p1_req,
  input  logic [DW/8-1:0] p1_we,
  input  logic [AW-1:0]   p1_addr,
  input  logic [DW-1:0]   p1_wdata,
  output logic            p0_gnt,
  output logic            p0_rvalid,
  output logic [DW-1:0]   p0_rdata,
  output logic            p1_gnt,
  output logic            p1_rvalid,
  output logic [DW-1:0]   p1_rdata,
  output logic            ram_en,
  output logic [DW/8-1:0] ram_we,
  output logic [AW-1:0]   ram_a,
  output logic [DW-1:0]   ram_di,
  input  logic [DW-1:0]   ram_do,
`ifdef RAM_ARB_STATS_EN
  input  logic            stat_clr,
  output logic [15:0]     stat_gnt0,
  output logic [15:0]     stat_gnt1,
  output logic [15:0]     stat_conflict,
`endif
  output logic            init_done
);

  localparam int BW = DW / 8;

  state_e        state_q;
  logic [AW-1:0] init_cnt_q;
  logic          init_done_q;
  rd_owner_t     rd_owner_q;
  logic          run;
  logic [1:0]    gnt;
  logic          en_c;
  logic [BW-1:0] we_c;
  logic [AW-1:0] a_c;
  logic [DW-1:0] di_c;

  assign run = (state_q == RUN);

  rr_arb2 u_arb (
    .CLK    (CLK),
    .RESETn (RESETn),
    .en_i   (run),
    .req_i  ({p1_req, p0_req}),
    .gnt_o  (gnt)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= INIT_ZERO ? INIT : RUN;
      init_cnt_q  <= '0;
      init_done_q <= !INIT_ZERO;
    end else if (state_q == INIT) begin
      init_cnt_q <= init_cnt_q + AW'(1);
      if (&init_cnt_q) begin
        state_q     <= RUN;
        init_done_q <= 1'b1;
      end
    end
  end

  always_comb begin
    en_c = 1'b0;
    we_c = '0;
    a_c  = '0;
    di_c = '0;
    if (!run) begin
      en_c = 1'b1;
      we_c = '1;
      a_c  = init_cnt_q;
    end else if (gnt[0]) begin
      en_c = 1'b1;
      we_c = p0_we;
      a_c  = p0_addr;
      di_c = p0_wdata;
    end else if (gnt[1]) begin
      en_c = 1'b1;
      we_c = p1_we;
      a_c  = p1_addr;
      di_c = p1_wdata;
    end
  end

  // Only reads leave an owner behind; writes complete with their grant.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rd_owner_q <= '0;
    end else begin
      rd_owner_q.valid <= run && (gnt != 2'b00) && (we_c == '0);
      rd_owner_q.port  <= gnt[1];
    end
  end

  // The INIT drive is state-derived, so gate every output while reset is held.
  assign ram_en    = RESETn & en_c;
  assign ram_we    = RESETn ? we_c : '0;
  assign ram_a     = RESETn ? a_c : '0;
  assign ram_di    = RESETn ? di_c : '0;
  assign p0_gnt    = RESETn & gnt[0];
  assign p1_gnt    = RESETn & gnt[1];
  assign p0_rvalid = rd_owner_q.valid & ~rd_owner_q.port;
  assign p1_rvalid = rd_owner_q.valid & rd_owner_q.port;
  assign p0_rdata  = p0_rvalid ? ram_do : '0;
  assign p1_rdata  = p1_rvalid ? ram_do : '0;
  assign init_done = RESETn & init_done_q;

`ifdef RAM_ARB_STATS_EN
  logic [15:0] st_g0_q, st_g1_q, st_cf_q;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      st_g0_q <= '0;
      st_g1_q <= '0;
      st_cf_q <= '0;
    end else if (stat_clr) begin
      st_g0_q <= '0;
      st_g1_q <= '0;
      st_cf_q <= '0;
    end else begin
      if (gnt[0] && st_g0_q != 16'hFFFF) st_g0_q <= st_g0_q + 16'd1;
      if (gnt[1] && st_g1_q != 16'hFFFF) st_g1_q <= st_g1_q + 16'd1;
      if (run && p0_req && p1_req && st_cf_q != 16'hFFFF) st_cf_q <= st_cf_q + 16'd1;
    end
  end

  assign stat_gnt0     = st_g0_q;
  assign stat_gnt1     = st_g1_q;
  assign stat_conflict = st_cf_q;
`endif

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Bench for ram_arbiter_2p: zero-fill sweeps, directed vector table, resets, and a randomized
// run checked against a transaction-level model of arbitration and memory contents.
module tb_ram_arbiter_2p;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        p0_req, p1_req;
  logic [3:0]  p0_we, p1_we;
  logic [11:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_a;
  logic [31:0] ram_di, ram_do;
  logic        init_done;
`ifdef RAM_ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  ram_arbiter_2p dut (
    .CLK(CLK), .RESETn(RESETn),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do),
`ifdef RAM_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1),
    .stat_conflict(stat_conflict),
`endif
    .init_done(init_done)
  );

  // Single-port RAM with registered, read-before-write output; drives 0 after an idle cycle.
  logic [31:0] mem [4096];
  always @(posedge CLK) begin
    if (ram_en) begin
      ram_do <= mem[ram_a];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_a][b*8 +: 8] <= ram_di[b*8 +: 8];
    end else begin
      ram_do <= 32'h0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, input logic [3:0] w0, input logic [11:0] a0,
                       input logic [31:0] d0, input logic r1, input logic [3:0] w1,
                       input logic [11:0] a1, input logic [31:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  // Checks n consecutive zero-fill cycles; the first sample is taken without waiting a cycle.
  task automatic sweep(input int n, input string name);
    int errs = 0;
    int first_bad = -1;
    for (int i = 0; i < n; i++) begin
      if (i != 0) @(negedge CLK);
      #1;
      if (ram_en !== 1'b1 || ram_we !== 4'hF || ram_di !== 32'h0 || ram_a !== 12'(i) ||
          p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 ||
          init_done !== 1'b0) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
    end
    chk({name, "_bad_cycles"}, 64'(errs), 64'd0);
    if (errs != 0) $display("  first bad sweep cycle %0d", first_bad);
  endtask

  typedef struct {
    logic r0; logic [3:0] w0; logic [11:0] a0; logic [31:0] d0;
    logic r1; logic [3:0] w1; logic [11:0] a1; logic [31:0] d1;
    logic [1:0] g; logic [1:0] rv; logic [31:0] rd0; logic [31:0] rd1;
  } vec_t;

  typedef struct {
    logic req; logic [3:0] we; logic [11:0] addr; logic [31:0] wdata;
  } txn_t;

  vec_t tv [17];
  logic [31:0] gold [4096];
  txn_t pend [2];
  logic [1:0]  exp_rv;
  logic [31:0] exp_rd [2];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    tv[0]  = '{1'b1, 4'hF, 12'h123, 32'hDEADBEEF, 1'b0, 4'h0, 12'h000, 32'h0, 2'b01, 2'b01, 32'h0, 32'h0};
    tv[1]  = '{1'b1, 4'h0, 12'h123, 32'h0, 1'b0, 4'h0, 12'h000, 32'h0, 2'b01, 2'b00, 32'h0, 32'h0};
    tv[2]  = '{1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 4'h0, 12'h000, 32'h0, 2'b00, 2'b01, 32'hDEADBEEF, 32'h0};
    tv[3]  = '{1'b1, 4'hF, 12'h010, 32'hA5A50010, 1'b0, 4'h0, 12'h000, 32'h0, 2'b01, 2'b00, 32'h0, 32'h0};
    tv[4]  = '{1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 4'hF, 12'h020, 32'h5A5A0020, 2'b10, 2'b00, 32'h0, 32'h0};
    tv[5]  = '{1'b1, 4'h0, 12'h010, 32'h0, 1'b1, 4'h0, 12'h020, 32'h0, 2'b01, 2'b00, 32'h0, 32'h0};
    tv[6]  = '{1'b1, 4'h0, 12'h010, 32'h0, 1'b1, 4'h0, 12'h020, 32'h0, 2'b10, 2'b01, 32'hA5A50010, 32'h0};
    tv[7]  = '{1'b1, 4'h0, 12'h010, 32'h0, 1'b1, 4'h0, 12'h020, 32'h0, 2'b01, 2'b10, 32'h0, 32'h5A5A0020};
    tv[8]  = '{1'b1, 4'h0, 12'h010, 32'h0, 1'b1, 4'h0, 12'h020, 32'h0, 2'b10, 2'b01, 32'hA5A50010, 32'h0};
    tv[9]  = '{1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 4'h0, 12'h000, 32'h0, 2'b00, 2'b10, 32'h0, 32'h5A5A0020};
    tv[10] = '{1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 4'hF, 12'h040, 32'h11223344, 2'b10, 2'b00, 32'h0, 32'h0};
    tv[11] = '{1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 4'h2, 12'h040, 32'h0000AB00, 2'b10, 2'b00, 32'h0, 32'h0};
    tv[12] = '{1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 4'h0, 12'h040, 32'h0, 2'b10, 2'b00, 32'h0, 32'h0};
    tv[13] = '{1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 4'h0, 12'h000, 32'h0, 2'b00, 2'b10, 32'h0, 32'h1122AB44};
    tv[14] = '{1'b1, 4'hF, 12'h050, 32'hCAFEF00D, 1'b1, 4'h0, 12'h050, 32'h0, 2'b01, 2'b00, 32'h0, 32'h0};
    tv[15] = '{1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 4'h0, 12'h050, 32'h0, 2'b10, 2'b00, 32'h0, 32'h0};
    tv[16] = '{1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 4'h0, 12'h000, 32'h0, 2'b00, 2'b10, 32'h0, 32'hCAFEF00D};

`ifdef RAM_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    // Reset with a request pending: every output must stay low.
    RESETn = 1'b0;
    drive(1'b1, 4'h0, 12'h000, 32'h0, 1'b0, 4'h0, 12'h000, 32'h0);
    repeat (3) @(negedge CLK);
    #1;
    chk("reset_outputs", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_en, ram_we, init_done},
        11'h0);
    chk("reset_buses", {ram_a, ram_di, p0_rdata, p1_rdata}, 108'h0);

    @(negedge CLK);
    RESETn = 1'b1;
    sweep(4096, "init_sweep");
    @(negedge CLK);
    #1;
    chk("init_done_rise", init_done, 1'b1);
    chk("first_grant_after_init", {p1_gnt, p0_gnt}, 2'b01);
    chk("first_grant_ram_we", ram_we, 4'h0);

    for (int i = 0; i < 17; i++) begin
      @(negedge CLK);
      drive(tv[i].r0, tv[i].w0, tv[i].a0, tv[i].d0, tv[i].r1, tv[i].w1, tv[i].a1, tv[i].d1);
      #1;
      chk($sformatf("tv%0d_gnt", i), {p1_gnt, p0_gnt}, tv[i].g);
      chk($sformatf("tv%0d_rvalid", i), {p1_rvalid, p0_rvalid}, tv[i].rv);
      chk($sformatf("tv%0d_rdata0", i), p0_rdata, tv[i].rd0);
      chk($sformatf("tv%0d_rdata1", i), p1_rdata, tv[i].rd1);
      chk($sformatf("tv%0d_ram_en", i), ram_en, |tv[i].g);
      chk($sformatf("tv%0d_ram_a", i), ram_a,
          tv[i].g[0] ? tv[i].a0 : (tv[i].g[1] ? tv[i].a1 : 12'h000));
    end

`ifdef RAM_ARB_STATS_EN
    // Clear while contending: the clear must win over the increments of that cycle.
    @(negedge CLK);
    drive(1'b1, 4'h0, 12'h010, 32'h0, 1'b1, 4'h0, 12'h020, 32'h0);
    stat_clr = 1'b1;
    @(negedge CLK);
    stat_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge CLK);
      #1;
      chk($sformatf("stat_alt%0d", i), {p1_gnt, p0_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    @(negedge CLK);
    drive(1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 4'h0, 12'h000, 32'h0);
    #1;
    chk("stat_conflict", stat_conflict, 16'd10);
    chk("stat_gnt0", stat_gnt0, 16'd5);
    chk("stat_gnt1", stat_gnt1, 16'd5);
    stat_clr = 1'b1;
    @(negedge CLK);
    stat_clr = 1'b0;
    #1;
    chk("stat_clr_all", {stat_gnt0, stat_gnt1, stat_conflict}, 48'h0);
`endif

    // Read granted, then reset lands before its data would return.
    @(negedge CLK);
    drive(1'b1, 4'h0, 12'h123, 32'h0, 1'b0, 4'h0, 12'h000, 32'h0);
    #1;
    chk("rst_read_gnt", p0_gnt, 1'b1);
    #2 RESETn = 1'b0;
    @(posedge CLK);
    #1;
    chk("rst_rvalid_dropped", {p0_rvalid, p1_rvalid, p0_rdata}, 34'h0);
    chk("rst_outputs_low", {p0_gnt, ram_en, init_done, ram_a}, 15'h0);
    @(negedge CLK);
    RESETn = 1'b1;
    sweep(2049, "partial_sweep");
    chk("partial_sweep_at_800", ram_a, 12'h800);
    #1 RESETn = 1'b0;
    #1;
    chk("midinit_reset_ram_en", ram_en, 1'b0);
    @(negedge CLK);
    RESETn = 1'b1;
    drive(1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 4'h0, 12'h000, 32'h0);
    sweep(4096, "restart_sweep");
    @(negedge CLK);
    #1;
    chk("restart_init_done", init_done, 1'b1);

    // Randomized traffic against a transaction-level model of memory and round-robin policy.
    for (int a = 0; a < 4096; a++) gold[a] = 32'h0;
    pend[0] = '{1'b0, 4'h0, 12'h0, 32'h0};
    pend[1] = '{1'b0, 4'h0, 12'h0, 32'h0};
    exp_rv = 2'b00;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    begin
      int lastp = 1;
      int eg;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(negedge CLK);
        for (int p = 0; p < 2; p++) begin
          if (!pend[p].req && $urandom_range(0, 2) != 0) begin
            pend[p].req   = 1'b1;
            pend[p].we    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            pend[p].addr  = 12'($urandom_range(0, 15));
            pend[p].wdata = $urandom;
          end
        end
        drive(pend[0].req, pend[0].we, pend[0].addr, pend[0].wdata,
              pend[1].req, pend[1].we, pend[1].addr, pend[1].wdata);
        #1;
        if (pend[0].req && pend[1].req) eg = 1 - lastp;
        else if (pend[0].req) eg = 0;
        else if (pend[1].req) eg = 1;
        else eg = -1;
        chk("rnd_gnt", {p1_gnt, p0_gnt}, (eg < 0) ? 2'b00 : ((eg == 0) ? 2'b01 : 2'b10));
        chk("rnd_rvalid", {p1_rvalid, p0_rvalid}, exp_rv);
        chk("rnd_rdata0", p0_rdata, exp_rv[0] ? exp_rd[0] : 32'h0);
        chk("rnd_rdata1", p1_rdata, exp_rv[1] ? exp_rd[1] : 32'h0);
        exp_rv = 2'b00;
        if (eg >= 0) begin
          chk("rnd_ram_a", ram_a, pend[eg].addr);
          if (pend[eg].we == 4'h0) begin
            exp_rv[eg] = 1'b1;
            exp_rd[eg] = gold[pend[eg].addr];
          end else begin
            for (int b = 0; b < 4; b++)
              if (pend[eg].we[b]) gold[pend[eg].addr][b*8 +: 8] = pend[eg].wdata[b*8 +: 8];
          end
          pend[eg].req = 1'b0;
          lastp = eg;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
